// File: rtl/arith_rr_scheduler.sv
// Purpose: round-robin share of one combinational arithmetic unit among NREQ requesters.
// Latency: accept at edge t -> rsp_valid after edge t+1; 1 op/cycle with rsp_ready high.
// Backpressure: stalled result holds both stages; a new request is taken only while the issue stage can move.
module arith_rr_scheduler #(
  parameter int BW   = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_mode,
  input  logic [BW*NREQ-1:0]   req_a,
  input  logic [BW*NREQ-1:0]   req_b,
  output logic [3:0]           alu_mode,
  output logic [BW-1:0]        alu_a,
  output logic [BW-1:0]        alu_b,
  input  logic [BW-1:0]        alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [BW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CW-1:0]        ops_done
);

  // issue stage registers (they drive the arithmetic unit directly)
  logic           iss_valid;
  logic [3:0]     iss_mode;
  logic [BW-1:0]  iss_a;
  logic [BW-1:0]  iss_b;
  logic [IDW-1:0] iss_id;
  logic [IDW-1:0] rr_ptr;

  logic res_load;
  logic iss_load;
  logic accept;
  logic rsp_fire;

  // arbitration helpers
  logic [NREQ-1:0] rot_valid;
  logic [NREQ-1:0] rot_gnt;
  logic [IDW:0]    rot_pos;
  logic [IDW:0]    gnt_sum;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  nxt_ptr;
  logic            any_valid;
  logic [3:0]      sel_mode;
  logic [BW-1:0]   sel_a;
  logic [BW-1:0]   sel_b;

  assign res_load = iss_valid && (!rsp_valid || rsp_ready);
  assign iss_load = !iss_valid || res_load;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Rotate so the pointer position sits at bit 0, then isolate the lowest
  // asserted request; its distance from the pointer gives the winner.
  assign rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr);
  assign rot_gnt   = rot_valid & (~rot_valid + NREQ'(1));
  assign rot_pos   = (IDW+1)'($countones(rot_gnt - NREQ'(1)));
  assign any_valid = |req_valid;
  assign gnt_sum   = {1'b0, rr_ptr} + rot_pos;
  assign gnt_idx   = (gnt_sum >= (IDW+1)'(NREQ)) ? IDW'(gnt_sum - (IDW+1)'(NREQ))
                                                 : IDW'(gnt_sum);
  assign nxt_ptr   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  // operand select of the winning requester from the flattened buses
  assign sel_mode = 4'(req_mode >> (4 * gnt_idx));
  assign sel_a    = BW'(req_a >> (BW * gnt_idx));
  assign sel_b    = BW'(req_b >> (BW * gnt_idx));

  assign req_ready = (!rst && iss_load && any_valid) ? (NREQ'(1) << gnt_idx) : '0;
  assign accept    = |req_ready;

  assign alu_mode = iss_mode;
  assign alu_a    = iss_a;
  assign alu_b    = iss_b;
  assign busy     = iss_valid || rsp_valid;

  // issue stage: capture the granted request and advance the RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_mode  <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_mode  <= sel_mode;
      iss_a     <= sel_a;
      iss_b     <= sel_b;
      iss_id    <= gnt_idx;
      rr_ptr    <= nxt_ptr;
    end else if (res_load) begin
      iss_valid <= 1'b0;
    end
  end

  // result stage: register the unit output; held stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (res_load) begin
      rsp_valid <= 1'b1;
      rsp_id    <= iss_id;
      rsp_data  <= alu_out;
      rsp_err   <= (iss_mode > 4'b0011) || ((iss_mode == 4'b0011) && (iss_b == '0));
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // completed-handshake counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_fire) begin
      ops_done <= ops_done + CW'(1);
    end
  end

endmodule

// File: tb/tb_arith_rr_scheduler.sv
// Bench for arith_rr_scheduler: models the external arithmetic unit, runs
// directed vectors and corner sequences, then random traffic against a
// transaction-level reference (queue of in-flight ops, capacity 2).
module tb_arith_rr_scheduler;
  localparam int BW   = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_ready_w;
  logic [3:0]  m_mode [NREQ];
  logic [31:0] m_a    [NREQ];
  logic [31:0] m_b    [NREQ];
  logic [4*NREQ-1:0]  req_mode;
  logic [BW*NREQ-1:0] req_a;
  logic [BW*NREQ-1:0] req_b;
  logic [3:0]  alu_mode, alu_mode_w;
  logic [31:0] alu_a, alu_b, alu_out, alu_a_w, alu_b_w, alu_out_w;
  logic rsp_valid, rsp_valid_w, rsp_ready, rsp_err, rsp_err_w, busy, busy_w;
  logic [IDW-1:0] rsp_id, rsp_id_w;
  logic [31:0] rsp_data, rsp_data_w;
  logic [15:0] ops_done;
  logic [3:0]  ops_done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_mode = '0;
    req_a    = '0;
    req_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mode[4*i +: 4] = m_mode[i];
      req_a[BW*i +: BW]  = m_a[i];
      req_b[BW*i +: BW]  = m_b[i];
    end
  end

  // external arithmetic unit: add/sub/mul-low/div, 0 for illegal or /0
  function automatic logic [31:0] alu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 32'd0 : 32'($signed(a) / $signed(b));
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out   = alu_fn(alu_mode, alu_a, alu_b);
  assign alu_out_w = alu_fn(alu_mode_w, alu_a_w, alu_b_w);

  arith_rr_scheduler #(.BW(BW), .NREQ(NREQ), .IDW(IDW), .CW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done));

  // narrow-counter copy sharing the same inputs, for the wrap check
  arith_rr_scheduler #(.BW(BW), .NREQ(NREQ), .IDW(IDW), .CW(4)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .alu_mode(alu_mode_w), .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_out(alu_out_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w),
    .rsp_data(rsp_data_w), .rsp_err(rsp_err_w), .busy(busy_w), .ops_done(ops_done_w));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    logic [31:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          acc;
  } op_t;

  initial begin
    vec_t tbl[9];
    op_t  q[$];
    op_t  op;
    int   ptr, edges, hs, g, idx;
    logic vis, drain, can;
    logic [NREQ-1:0] exp_rdy;

    tbl[0] = '{4'h0, 32'd7,        32'hFFFFFFFD, 1, 32'd4,        1'b0};
    tbl[1] = '{4'h3, 32'd10,       32'd0,        0, 32'd0,        1'b1};
    tbl[2] = '{4'h7, 32'd5,        32'd5,        2, 32'd0,        1'b1};
    tbl[3] = '{4'h2, 32'hFFFFFFFC, 32'd6,        3, 32'hFFFFFFE8, 1'b0};
    tbl[4] = '{4'h1, 32'd5,        32'd9,        2, 32'hFFFFFFFC, 1'b0};
    tbl[5] = '{4'h3, 32'hFFFFFFEC, 32'd3,        0, 32'hFFFFFFFA, 1'b0};
    tbl[6] = '{4'h2, 32'h00010000, 32'h00010000, 1, 32'd0,        1'b0};
    tbl[7] = '{4'h4, 32'd1,        32'd1,        3, 32'd0,        1'b1};
    tbl[8] = '{4'h3, 32'd100,      32'd7,        1, 32'd14,       1'b0};

    for (int i = 0; i < NREQ; i++) begin
      m_mode[i] = '0; m_a[i] = '0; m_b[i] = '0;
    end

    // reset state, with requests pending while rst is high
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_alu", {alu_mode, alu_a, alu_b}, 0);
    req_valid = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    tick();

    // directed single operations
    for (int n = 0; n < 9; n++) begin
      m_mode[tbl[n].id] = tbl[n].mode;
      m_a[tbl[n].id]    = tbl[n].a;
      m_b[tbl[n].id]    = tbl[n].b;
      req_valid = NREQ'(1) << tbl[n].id;
      @(negedge clk);
      chk("vec_ready", req_ready, NREQ'(1) << tbl[n].id);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("vec_lat1_valid", rsp_valid, 0);
      chk("vec_lat1_busy", busy, 1);
      tick();
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_id", rsp_id, tbl[n].id);
      chk("vec_rsp_data", rsp_data, tbl[n].data);
      chk("vec_rsp_err", rsp_err, tbl[n].err);
      tick();
      chk("vec_ops_done", ops_done, n + 1);
    end

    // fairness, back-to-back, and 4-bit counter wrap after 17 handshakes
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_mode[i] = 4'h0; m_a[i] = i; m_b[i] = 32'd100;
    end
    req_valid = '1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      chk("fair_grant", req_ready, NREQ'(1) << (c % NREQ));
      if (c >= 2) begin
        chk("fair_valid", rsp_valid, 1);
        chk("fair_id", rsp_id, (c - 2) % NREQ);
        chk("fair_data", rsp_data, (c - 2) % NREQ + 100);
      end else begin
        chk("fair_valid_early", rsp_valid, 0);
      end
      tick();
    end
    chk("fair_ops_done", ops_done, 17);
    chk("wrap_ops_done", ops_done_w, 1);
    req_valid = '0;
    tick();
    tick();

    // backpressure: one extra accept, then stall with stable outputs
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_mode[i] = 4'h0; m_a[i] = 3 * i; m_b[i] = 32'd1;
    end
    rsp_ready = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("bp_grant0", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    chk("bp_grant1", req_ready, 4'b0010);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_no_grant", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_data", rsp_data, 1);
      chk("bp_alu_hold", alu_a, 3);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain0", {rsp_valid, 30'd0, rsp_id, rsp_data}, {1'b1, 30'd0, 2'd0, 32'd1});
    tick();
    @(negedge clk);
    chk("bp_drain1", {rsp_valid, 30'd0, rsp_id, rsp_data}, {1'b1, 30'd0, 2'd1, 32'd4});
    tick();
    @(negedge clk);
    chk("bp_empty", {rsp_valid, busy}, 0);
    chk("bp_ops_done", ops_done, 2);
    tick();

    // asynchronous reset with both stages full
    rsp_ready = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("mid_grant2", req_ready, 4'b0100);
    tick();
    @(negedge clk);
    chk("mid_grant3", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    chk("mid_full", {busy, rsp_valid, req_ready}, {1'b1, 1'b1, 4'b0000});
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ops", ops_done, 0);
    chk("mid_rst_ready", req_ready, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("mid_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // random traffic against the transaction-level model
    do_reset();
    q.delete();
    ptr = 0; edges = 0; hs = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        m_mode[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        m_a[i]    = $urandom;
        m_b[i]    = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      end
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vis   = (q.size() > 0) && (edges >= q[0].acc + 2);
      drain = vis && rsp_ready;
      can   = (q.size() - (drain ? 1 : 0)) < 2;
      g = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_valid", rsp_valid, vis);
      chk("rnd_busy", busy, q.size() > 0);
      chk("rnd_ops_done", ops_done, hs[15:0]);
      chk("rnd_ops_wrap", ops_done_w, hs[3:0]);
      if (vis) begin
        chk("rnd_id", rsp_id, q[0].id);
        chk("rnd_data", rsp_data, q[0].data);
        chk("rnd_err", rsp_err, q[0].err);
      end
      if (g >= 0) begin
        op.id   = g;
        op.data = alu_fn(m_mode[g], m_a[g], m_b[g]);
        op.err  = (m_mode[g] > 4'd3) || (m_mode[g] == 4'd3 && m_b[g] == 32'd0);
        op.acc  = edges;
      end
      @(posedge clk);
      if (drain) begin
        void'(q.pop_front());
        hs++;
      end
      if (g >= 0) begin
        q.push_back(op);
        ptr = (g + 1) % NREQ;
      end
      edges++;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
